adc_pipe_stage_code_gen: RTL and testbench

- Digital stimulus generator that drives the pipelined ADC encoder's stage-decision inputs; it runs in the opposite direction to the encoder.
- Takes target 3-bit output codes and decomposes each into ideal 1.5-bit stage decisions: d1 and d2 as one-hot, d3 as a single bit.
- Applies the pipeline skew between stages, then emits the aligned expected code so a checker can compare it against the encoder's d_o.
- Used for encoder BIST and for digital-only regression without an analog front-end.

---
 rtl/adc_pipe_pkg.sv | 65 ++++++
 rtl/adc_pipe_stage_delay.sv | 58 +++++
 rtl/adc_pipe_stage_code_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_pipe_stage_code_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adc_pipe_pkg
// Shared definitions for the pipelined-ADC stage-decision stimulus generator:
// one-hot 1.5-bit digit encodings, the code width, the generator FSM state
// type and the two code -> (d1, d2, d3) decomposition tables.
// The alternate table is only selected by the top when ADC_PIPE_ALT_DECOMP_EN
// is defined.
// -----------------------------------------------------------------------------
package adc_pipe_pkg;

  localparam int CODE_W = 3;

  // One-hot stage digits: +2, +1 and 0.
  localparam logic [2:0] DIG_P2 = 3'b100;
  localparam logic [2:0] DIG_P1 = 3'b001;
  localparam logic [2:0] DIG_Z  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] d1;
    logic [2:0] d2;
    logic       d3;
  } decomp_t;

  // Canonical decomposition: non-redundant digits, D = 2*b1 + b2 + b3.
  function automatic decomp_t canon_decomp(input logic [CODE_W-1:0] code);
    decomp_t r;
    case (code)
      3'd0:    r = '{d1: DIG_Z,  d2: DIG_Z,  d3: 1'b0};
      3'd1:    r = '{d1: DIG_Z,  d2: DIG_P1, d3: 1'b0};
      3'd2:    r = '{d1: DIG_P1, d2: DIG_Z,  d3: 1'b0};
      3'd3:    r = '{d1: DIG_P1, d2: DIG_P1, d3: 1'b0};
      3'd4:    r = '{d1: DIG_P1, d2: DIG_P1, d3: 1'b1};
      3'd5:    r = '{d1: DIG_P1, d2: DIG_P2, d3: 1'b1};
      3'd6:    r = '{d1: DIG_P2, d2: DIG_P1, d3: 1'b1};
      3'd7:    r = '{d1: DIG_P2, d2: DIG_P2, d3: 1'b1};
      default: r = '{d1: DIG_Z,  d2: DIG_Z,  d3: 1'b0};
    endcase
    return r;
  endfunction

  // Alternate decomposition: only digits 0 and 2 in the first two stages, so
  // the encoder's overlap (redundancy) correction path is exercised.
  function automatic decomp_t alt_decomp(input logic [CODE_W-1:0] code);
    decomp_t r;
    case (code)
      3'd0:    r = '{d1: DIG_Z,  d2: DIG_Z,  d3: 1'b0};
      3'd1:    r = '{d1: DIG_Z,  d2: DIG_Z,  d3: 1'b1};
      3'd2:    r = '{d1: DIG_Z,  d2: DIG_P2, d3: 1'b0};
      3'd3:    r = '{d1: DIG_Z,  d2: DIG_P2, d3: 1'b1};
      3'd4:    r = '{d1: DIG_P2, d2: DIG_Z,  d3: 1'b0};
      3'd5:    r = '{d1: DIG_P2, d2: DIG_Z,  d3: 1'b1};
      3'd6:    r = '{d1: DIG_P2, d2: DIG_P2, d3: 1'b0};
      3'd7:    r = '{d1: DIG_P2, d2: DIG_P2, d3: 1'b1};
      default: r = '{d1: DIG_Z,  d2: DIG_Z,  d3: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adc_pipe_stage_delay.sv
// -----------------------------------------------------------------------------
// adc_pipe_stage_delay
// Fixed-depth shift register carrying a data word plus a valid bit. A slot
// entered without valid (a bubble) is loaded with RST_VAL, so bubbles show up
// downstream as the idle/zero value.
// Ports:
//   clk_i     in   clock
//   reset_ni  in   asynchronous active-low reset (all slots -> RST_VAL, invalid)
//   data_i    in   WIDTH  word entering the line
//   valid_i   in   1      word entering the line is a real sample
//   data_o    out  WIDTH  word DEPTH cycles later (registered)
//   valid_o   out  1      valid DEPTH cycles later (registered)
// -----------------------------------------------------------------------------
module adc_pipe_stage_delay #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Shift by one slot; bubbles enter as RST_VAL.
  always_comb begin
    data_d[0]  = valid_i ? data_i : RST_VAL;
    valid_d[0] = valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i]  = data_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // Delay-line storage.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/adc_pipe_stage_code_gen.sv
// -----------------------------------------------------------------------------
// adc_pipe_stage_code_gen
// Stimulus generator for a pipelined ADC encoder. Target 3-bit codes (stream,
// ramp or constant) are decomposed into 1.5-bit stage decisions; stage 2 and
// stage 3 are delayed by STAGE_SKEW per stage, and the expected encoder code
// follows the final stage by ENC_LAT cycles.
// Optional feature macro: ADC_PIPE_ALT_DECOMP_EN -- when defined, alt_i picks
// the redundant decomposition per issued sample; otherwise alt_i is ignored.
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   start_i                  start pulse (IDLE only)
//   mode_i[1:0]              00 stream, 01 ramp, 10/11 constant
//   count_i[CNT_W-1:0]       samples per run, 0 = 2^CNT_W
//   code_i[2:0]              stream sample / constant value
//   code_valid_i/code_ready_o stream handshake
//   alt_i                    alternate decomposition select
//   d1_o[2:0], d2_o[2:0]     one-hot stage decisions
//   d3_o                     final-stage bit
//   exp_o[2:0], exp_valid_o  expected encoder output
//   busy_o, done_o           FSM not idle, end-of-run pulse
// -----------------------------------------------------------------------------
module adc_pipe_stage_code_gen
  import adc_pipe_pkg::*;
#(
  parameter int STAGE_SKEW = 1,
  parameter int ENC_LAT    = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [2:0]       code_i,
  input  logic             code_valid_i,
  output logic             code_ready_o,
  input  logic             alt_i,
  output logic [2:0]       d1_o,
  output logic [2:0]       d2_o,
  output logic             d3_o,
  output logic [2:0]       exp_o,
  output logic             exp_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  // Cycles from the last issue until that sample has left the exp pipeline.
  localparam int              FLUSH_LEN = 1 + 2*STAGE_SKEW + ENC_LAT;
  localparam int              FLUSH_W   = $clog2(FLUSH_LEN + 1);
  localparam logic [CNT_W:0]  REM_FULL  = {1'b1, {CNT_W{1'b0}}};

  state_e               state_q, state_d;
  logic [1:0]           mode_q,  mode_d;
  logic [CODE_W-1:0]    const_q, const_d;
  logic [CODE_W-1:0]    ramp_q,  ramp_d;
  logic [CNT_W:0]       rem_q,   rem_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic                 done_q,  done_d;
  logic                 busy_q,  busy_d;
  logic                 ready_q, ready_d;

  logic                 issue_s;
  logic [CODE_W-1:0]    sample_s;
  decomp_t              dec_s;
  logic                 d1_valid_unused_s;
  logic                 d2_valid_unused_s;
  logic                 d3_valid_unused_s;

  // Select the sample issued this cycle (at most one, RUN only).
  always_comb begin
    issue_s  = 1'b0;
    sample_s = 3'd0;
    if (state_q == ST_RUN) begin
      case (mode_q)
        2'b00: begin
          issue_s  = code_valid_i & ready_q;
          sample_s = code_i;
        end
        2'b01: begin
          issue_s  = 1'b1;
          sample_s = ramp_q;
        end
        default: begin
          issue_s  = 1'b1;
          sample_s = const_q;
        end
      endcase
    end else begin
      issue_s  = 1'b0;
      sample_s = 3'd0;
    end
  end

`ifdef ADC_PIPE_ALT_DECOMP_EN
  // Decompose the issued sample; alt_i picks the redundant table.
  always_comb begin
    if (alt_i) begin
      dec_s = alt_decomp(sample_s);
    end else begin
      dec_s = canon_decomp(sample_s);
    end
  end
  assign d1_valid_unused_s = 1'b0;
`else
  // Decompose the issued sample with the canonical table only.
  always_comb begin
    dec_s = canon_decomp(sample_s);
  end
  // alt_i has no function in this build.
  assign d1_valid_unused_s = alt_i;
`endif

  // Run-control FSM next-state logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    const_d = const_q;
    ramp_d  = ramp_q;
    rem_d   = rem_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          mode_d  = mode_i;
          rem_d   = (count_i == {CNT_W{1'b0}}) ? REM_FULL : {1'b0, count_i};
          ramp_d  = 3'd0;
          // Modes 10 and 11 both run as constant.
          if (mode_i[1]) begin
            const_d = code_i;
          end else begin
            const_d = const_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          rem_d  = rem_q - {{CNT_W{1'b0}}, 1'b1};
          ramp_d = ramp_q + 3'd1;
          if (rem_q == {{CNT_W{1'b0}}, 1'b1}) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // done_o is raised while still in FLUSH, so a start_i seen alongside
        // done_o is ignored; the FSM returns to IDLE on the following edge.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (flush_q == FLUSH_W'(FLUSH_LEN - 1)) begin
          done_d = 1'b1;
        end else begin
          flush_d = flush_q + {{(FLUSH_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_RUN) && (mode_d == 2'b00);
  end

  // Run-control state registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'b00;
      const_q <= 3'd0;
      ramp_q  <= 3'd0;
      rem_q   <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      const_q <= const_d;
      ramp_q  <= ramp_d;
      rem_q   <= rem_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign code_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  adc_pipe_stage_delay #(.DEPTH(1), .WIDTH(3), .RST_VAL(DIG_Z)) u_d1 (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(dec_s.d1), .valid_i(issue_s),
    .data_o(d1_o), .valid_o(d2_valid_unused_s)
  );

  adc_pipe_stage_delay #(.DEPTH(1 + STAGE_SKEW), .WIDTH(3), .RST_VAL(DIG_Z)) u_d2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(dec_s.d2), .valid_i(issue_s),
    .data_o(d2_o), .valid_o(d3_valid_unused_s)
  );

  adc_pipe_stage_delay #(.DEPTH(1 + 2*STAGE_SKEW), .WIDTH(1), .RST_VAL(1'b0)) u_d3 (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(dec_s.d3), .valid_i(issue_s),
    .data_o(d3_o), .valid_o()
  );

  adc_pipe_stage_delay #(.DEPTH(1 + 2*STAGE_SKEW + ENC_LAT), .WIDTH(3), .RST_VAL(3'd0)) u_exp (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(sample_s), .valid_i(issue_s),
    .data_o(exp_o), .valid_o(exp_valid_o)
  );

endmodule

// File: tb/tb_adc_pipe_stage_code_gen.sv
// -----------------------------------------------------------------------------
// tb_adc_pipe_stage_code_gen
// Randomised runs in every mode; each issued sample pushes its expected stage
// decisions (keyed by the cycle they must appear) and expected code into a
// scoreboard, and a negedge monitor compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_adc_pipe_stage_code_gen;

  localparam int SKEW = 1;
  localparam int LAT  = 1;
  localparam logic [2:0] OH_Z  = 3'b010;
  localparam logic [2:0] OH_P1 = 3'b001;
  localparam logic [2:0] OH_P2 = 3'b100;
`ifdef ADC_PIPE_ALT_DECOMP_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic [7:0] count_i = 8'd0;
  logic [2:0] code_i = 3'd0;
  logic       code_valid_i = 1'b0;
  logic       alt_i = 1'b0;
  logic       code_ready_o;
  logic [2:0] d1_o, d2_o, exp_o;
  logic       d3_o, exp_valid_o, busy_o, done_o;

  adc_pipe_stage_code_gen dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .mode_i(mode_i),
    .count_i(count_i), .code_i(code_i), .code_valid_i(code_valid_i),
    .code_ready_o(code_ready_o), .alt_i(alt_i), .d1_o(d1_o), .d2_o(d2_o),
    .d3_o(d3_o), .exp_o(exp_o), .exp_valid_o(exp_valid_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int due;
    int code;
  } sb_t;

  sb_t        sb[$];
  logic [2:0] m_d1[int];
  logic [2:0] m_d2[int];
  logic       m_d3[int];
  int cyc = 0;
  int done_due = -1;
  int n_vec = 0;
  int n_fail = 0;

  // Digit values (b1, b2, b3) per code, straight from the decomposition tables.
  int cb1[8] = '{0, 0, 1, 1, 1, 1, 2, 2};
  int cb2[8] = '{0, 1, 0, 1, 1, 2, 1, 2};
  int cb3[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int ab1[8] = '{0, 0, 0, 0, 2, 2, 2, 2};
  int ab2[8] = '{0, 0, 2, 2, 0, 0, 2, 2};
  int ab3[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] onehot(input int b);
    if (b == 2) return OH_P2;
    if (b == 1) return OH_P1;
    return OH_Z;
  endfunction

  // Record the expected observations for a sample issued at edge k.
  task automatic push_issue(input int k, input int code, input logic alt);
    int b1, b2, b3;
    b1 = cb1[code];
    b2 = cb2[code];
    b3 = cb3[code];
    if (ALT_EN && alt) begin
      b1 = ab1[code];
      b2 = ab2[code];
      b3 = ab3[code];
    end
    m_d1[k] = onehot(b1);
    m_d2[k + SKEW] = onehot(b2);
    m_d3[k + 2*SKEW] = (b3 == 1);
    sb.push_back('{k + 2*SKEW + LAT, code});
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk_i) begin
    logic [2:0] e1, e2;
    logic       e3;
    sb_t        ent;
    e1 = m_d1.exists(cyc) ? m_d1[cyc] : OH_Z;
    e2 = m_d2.exists(cyc) ? m_d2[cyc] : OH_Z;
    e3 = m_d3.exists(cyc) ? m_d3[cyc] : 1'b0;
    check("d1", int'(d1_o), int'(e1));
    check("d2", int'(d2_o), int'(e2));
    check("d3", int'(d3_o), int'(e3));
    if (exp_valid_o) begin
      if (sb.size() == 0) begin
        check("exp_valid_extra", int'(exp_valid_o), 0);
      end else begin
        ent = sb.pop_front();
        check("exp_code", int'(exp_o), ent.code);
        check("exp_cycle", cyc, ent.due);
      end
    end else begin
      check("exp_idle_zero", int'(exp_o), 0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("exp_valid_missing", int'(exp_valid_o), 1);
        ent = sb.pop_front();
      end
    end
    check("done", int'(done_o), (cyc == done_due) ? 1 : 0);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d1"}, int'(d1_o), int'(OH_Z));
    check({tag, "_d2"}, int'(d2_o), int'(OH_Z));
    check({tag, "_d3"}, int'(d3_o), 0);
    check({tag, "_exp"}, int'(exp_o), 0);
    check({tag, "_expv"}, int'(exp_valid_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_ready"}, int'(code_ready_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
  endtask

  // One run: n in 1..256 samples; abort_at > 0 resets after that many issues.
  task automatic do_run(input logic [1:0] m, input int n, input logic [2:0] cval,
                        input int vprob, input int abort_at);
    int   rem, ramp, issued, smp, last;
    logic a, issue;
    start_i = 1'b1;
    mode_i = m;
    count_i = n[7:0];
    code_i = cval;
    code_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rem = n; ramp = 0; issued = 0; last = cyc; smp = 0;
    while (rem > 0) begin
      a = 1'($urandom_range(1));
      alt_i = a;
      start_i = ($urandom_range(7) == 0);
      mode_i = 2'($urandom_range(3));
      count_i = 8'($urandom_range(255));
      check("code_ready", int'(code_ready_o), (m == 2'b00) ? 1 : 0);
      check("busy_run", int'(busy_o), 1);
      if (m == 2'b00) begin
        issue = ($urandom_range(99) < vprob);
        code_valid_i = issue;
        smp = $urandom_range(7);
        code_i = 3'(smp);
      end else begin
        issue = 1'b1;
        code_valid_i = 1'($urandom_range(1));
        code_i = 3'($urandom_range(7));
        smp = (m == 2'b01) ? ramp : int'(cval);
      end
      @(posedge clk_i); #1;
      if (issue) begin
        push_issue(cyc, smp, a);
        rem--;
        ramp = (ramp + 1) % 8;
        issued++;
        last = cyc;
      end
      if (abort_at > 0 && issued == abort_at) begin
        start_i = 1'b0;
        code_valid_i = 1'b0;
        #1 reset_ni = 1'b0;
        m_d1.delete();
        m_d2.delete();
        m_d3.delete();
        sb.delete();
        done_due = -1;
        #1 check_reset_outputs("midrun_reset");
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        return;
      end
    end
    start_i = 1'b0;
    code_valid_i = 1'b0;
    check("ready_after_last", int'(code_ready_o), 0);
    check("busy_flush", int'(busy_o), 1);
    done_due = last + 1 + 2*SKEW + LAT;
    repeat (1 + 2*SKEW + LAT) @(posedge clk_i);
    #1;
    check("busy_at_done", int'(busy_o), 1);
    // A start coinciding with done_o must be ignored.
    start_i = 1'b1;
    mode_i = 2'b01;
    count_i = 8'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("busy_after_done", int'(busy_o), 0);
    @(posedge clk_i); #1;
    check("start_at_done_ignored", int'(busy_o), 0);
  endtask

  initial begin
    reset_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check_reset_outputs("por");
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    do_run(2'b01, 8, 3'd0, 100, 0);                       // ramp 0..7
    do_run(2'b10, $urandom_range(1, 20), 3'($urandom_range(7)), 100, 0);
    do_run(2'b00, 3, 3'd0, 60, 0);                        // short stream
    do_run(2'b00, 40, 3'd0, 70, 0);                       // stream with bubbles
    do_run(2'b01, 256, 3'd0, 100, 0);                     // count_i = 0
    do_run(2'b01, 8, 3'd0, 100, 3);                       // reset mid-run
    do_run(2'b01, 8, 3'd0, 100, 0);                       // normal after reset
    do_run(2'b11, 5, 3'd4, 100, 0);                       // reserved = constant
    for (int r = 0; r < 5; r++) begin
      do_run(2'($urandom_range(3)), $urandom_range(1, 30), 3'($urandom_range(7)),
             $urandom_range(30, 90), 0);
    end

    repeat (3) @(posedge clk_i);
    #1 check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
